// File: rtl/cache_mgmt_unit.sv
// Cache management unit: sequences lookup, dirty-victim write-back and line fill
// between the CPU memory stage and a 2-way set-associative cache array.
module cache_mgmt_unit #(
  parameter int ADDR_BITS       = 32,
  parameter int TAG_BITS        = 23,
  parameter int SET_INDEX_WIDTH = 5,
  parameter int LINE_WORDS      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_store,
  output logic                 cache_edit,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [31:0]          cache_dout,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, CHECK, BACK, FILL} state_e;

  state_e                       state_q, state_d;
  logic [OFFSET_BITS-1:0]       word_cnt_q, word_cnt_d;
  logic                         rd_ok_q, rd_ok_d;
  logic [TAG_BITS-1:0]          req_tag_q, req_tag_d;
  logic [TAG_BITS-1:0]          vtag_q, vtag_d;
  logic [SET_INDEX_WIDTH-1:0]   index_q, index_d;
  logic [31:0]                  hit_cnt_q, hit_cnt_d;
  logic [31:0]                  miss_cnt_q, miss_cnt_d;

  logic                         req;
  logic [ADDR_BITS-1:0]         line_addr;
  logic [ADDR_BITS-1:0]         victim_addr;

  assign req         = en_r | en_w;
  assign line_addr   = {req_tag_q, index_q, word_cnt_q, 2'b00};
  assign victim_addr = {vtag_q, index_q, word_cnt_q, 2'b00};
  assign stall       = req & ~((state_q == CHECK) & cache_hit);
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    rd_ok_d       = 1'b0;
    req_tag_d     = req_tag_q;
    vtag_d        = vtag_q;
    index_d       = index_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    data_r        = '0;
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_store   = 1'b0;
    cache_edit    = 1'b0;
    cache_u_b_h_w = '0;
    cache_din     = '0;
    mem_cs_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          cache_addr    = addr_rw;
          cache_load    = en_r & ~en_w;
          cache_edit    = en_w;
          cache_din     = data_w;
          cache_u_b_h_w = u_b_h_w;
          state_d       = CHECK;
        end
      end

      CHECK: begin
        if (cache_hit) begin
          data_r    = cache_dout;
          hit_cnt_d = hit_cnt_q + 32'd1;
          state_d   = IDLE;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          req_tag_d  = addr_rw[ADDR_BITS-1 -: TAG_BITS];
          index_d    = addr_rw[OFFSET_BITS+2 +: SET_INDEX_WIDTH];
          vtag_d     = cache_tag;
          word_cnt_d = '0;
          state_d    = (cache_valid & cache_dirty) ? BACK : FILL;
        end
      end

      BACK: begin
        // The cache returns the addressed victim word one cycle later, so the
        // memory request waits for rd_ok after each word_cnt change.
        cache_addr = line_addr;
        rd_ok_d    = 1'b1;
        mem_cs_o   = rd_ok_q;
        mem_we_o   = 1'b1;
        mem_addr_o = victim_addr;
        mem_data_o = cache_dout;
        if (rd_ok_q && mem_ack_i) begin
          rd_ok_d    = 1'b0;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) state_d = FILL;
        end
      end

      FILL: begin
        mem_cs_o   = 1'b1;
        mem_addr_o = line_addr;
        if (mem_ack_i) begin
          cache_store   = 1'b1;
          cache_addr    = line_addr;
          cache_din     = mem_data_i;
          cache_u_b_h_w = 3'b010;
          word_cnt_d    = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      rd_ok_q    <= 1'b0;
      req_tag_q  <= '0;
      vtag_q     <= '0;
      index_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      rd_ok_q    <= rd_ok_d;
      req_tag_q  <= req_tag_d;
      vtag_q     <= vtag_d;
      index_q    <= index_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
